// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port Data_Memory arbiter: default widths,
// FSM state encoding and requester port ids.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic P_DCACHE = 1'b0;
    localparam logic P_ICACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// win last time is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the single Data_Memory port,
// one transaction in flight. Optional ack watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [LINE_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [LINE_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LINE_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [LINE_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              busy_o,
    output logic              err_o
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t state;
    logic       grant;
    logic       last_grant;
    logic       pick_winner;
    logic       pick_any;
    logic       timeout_hit;

    rr_pick2 u_pick (
        .req    ({m1_enable_i, m0_enable_i}),
        .last   (last_grant),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Read data is broadcast; only the acked port may consume it.
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;
    assign m0_ack_o  = (state == BUSY) && mem_ack_i && (grant == P_DCACHE);
    assign m1_ack_o  = (state == BUSY) && mem_ack_i && (grant == P_ICACHE);
    assign busy_o    = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == BUSY) && !mem_ack_i && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state != BUSY) begin
            wait_cnt <= '0;
        end else if (!mem_ack_i) begin
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // RELEASE gives the acked requester one cycle to drop its enable before
    // the next arbitration, so a still-high stale request is never regranted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            grant        <= P_DCACHE;
            last_grant   <= P_ICACHE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant        <= pick_winner;
                        last_grant   <= pick_winner;
                        mem_enable_o <= 1'b1;
                        if (pick_winner == P_ICACHE) begin
                            mem_write_o <= m1_write_i;
                            mem_addr_o  <= m1_addr_i;
                            mem_data_o  <= m1_data_i;
                        end else begin
                            mem_write_o <= m0_write_i;
                            mem_addr_o  <= m0_addr_i;
                            mem_data_o  <= m0_data_i;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack_i || timeout_hit) begin
                        mem_enable_o <= 1'b0;
                        state        <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single off-chip Data_Memory port (256-bit line, enable/write/ack handshake) between the data cache (port 0) and the instruction cache or refill/prefetch engine (port 1).
It sits between the caches and Data_Memory inside the CPU top.
Round-robin fairness applies, with one outstanding memory transaction at a time.
Each request is held registered on the memory side until ack.

Parameters:
ADDR_W, 32, byte address width on all ports
LINE_W, 256, cache-line data width
TIMEOUT, 64, max cycles to wait for mem_ack_i (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
m0_enable_i  in  1  port 0 (dcache) request; level, held until m0_ack_o
m0_write_i  in  1  port 0: 1=write line, 0=read line
m0_addr_i  in  ADDR_W  port 0 line address
m0_data_i  in  LINE_W  port 0 write data
m0_ack_o  out  1  port 0 transaction done (1-cycle pulse)
m0_data_o  out  LINE_W  port 0 read data, valid when m0_ack_o
m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o  same as port 0, for port 1
mem_enable_o  out  1  to Data_Memory enable_i
mem_write_o  out  1  to Data_Memory write_i
mem_addr_o  out  ADDR_W  to Data_Memory addr_i
mem_data_o  out  LINE_W  to Data_Memory data_i
mem_ack_i  in  1  from Data_Memory ack_o
mem_data_i  in  LINE_W  from Data_Memory data_o
busy_o  out  1  transaction in flight (state != IDLE)
err_o  out  1  sticky timeout flag (constant 0 without feature)

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; mem_enable_o, mem_write_o, busy_o, err_o = 0.
  - mem_addr_o, mem_data_o = 0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset mid-transaction aborts immediately with no ack; Data_Memory is reset by the same system reset.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any mX_enable_i is sampled high at a clock edge, pick a winner.
  - Only one requesting: that one wins.
  - Both requesting: the port != last_grant wins.
  - On the same edge: latch winner's write/addr/data into mem_*_o, set mem_enable_o=1, grant=winner, last_grant=winner, go to BUSY.
  - Latency: request sampled at edge N -> mem_enable_o high after edge N.
- BUSY:
  - mem_* outputs held stable.
  - mX_ack_o = mem_ack_i & (grant==X), combinational, same cycle.
  - mX_data_o = mem_data_i for both ports (broadcast); only the acked port may consume it.
  - On the edge where mem_ack_i=1: mem_enable_o <= 0, go to RELEASE.
- RELEASE:
  - One idle cycle; requests are ignored so the acked requester can drop its enable. Then go to IDLE.
  - A port waiting during BUSY is granted at the first IDLE edge, i.e. 2 cycles after the ack edge.
  - Back-to-back requests from the same port while the other waits: the other port wins, so there is no starvation.
- Enable dropped by the granted requester mid-BUSY is a protocol violation: the transaction still completes and the ack is still pulsed.
- mem_ack_i while IDLE/RELEASE: ignored, no mX_ack_o.
- The non-granted port's ack is never asserted.
- Requester inputs may change freely while that port is not granted; only the IDLE-edge sample matters.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT: set err_o=1 (sticky until reset), deassert mem_enable_o, go to RELEASE; no mX_ack_o is issued.
- Undefined: no counter; err_o tied 0; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg: ADDR_W/LINE_W defaults; state encoding (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2); port-id constants P_DCACHE=1'b0, P_ICACHE=1'b1.
- Sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last -> winner, any).
- FSM, output registers and the optional timeout stay in mem_arbiter.

Test Plan:
- m0 read only, addr 0x0000_0020, memory returns line 1 after 10 cycles -> mem_enable_o rises 1 cycle after request; m0_ack_o pulses 1 cycle with m0_data_o=0x8888_9999_..._0000; m1_ack_o stays 0.
- m0 and m1 assert on the same edge after reset (m0 read 0x0, m1 read 0x400) -> m0 served first; m1 granted 2 cycles after m0 ack, with mem_addr_o=0x400.
- m0 re-requests immediately after each ack while m1 is held high -> grants alternate m0,m1,m0,m1; no port gets two consecutive grants while the other waits.
- m1 write of 256'hECFA… to 0x0240 -> mem_write_o=1 and mem_data_o matches; Data_Memory.memory[18] is updated; m1_ack_o pulses once.
- rst_i pulled low mid-BUSY -> mem_enable_o=0 asynchronously, no ack pulse; after release a fresh m0 request is served normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=64, and ack never returned -> after 64 BUSY cycles err_o=1 and mem_enable_o=0; the next request is granted and err_o stays 1.
